// File: rtl/rca4_sum_accumulator_if.sv
// Valid/ready bundle between the 4-bit adder result stream and its block-sum sink.
// The accumulator binds to the slave modport; the producer/consumer side binds to master.
interface rca4_sum_accumulator_if #(
  parameter int unsigned ACC_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_sum;
  logic                 in_cout;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_acc;
  logic                 out_ovf;
  logic [7:0]           out_cnt;

  modport master (
    output in_valid, in_sum, in_cout, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf, out_cnt
  );

  modport slave (
    input  in_valid, in_sum, in_cout, out_ready,
    output in_ready, out_valid, out_acc, out_ovf, out_cnt
  );
endinterface

// File: rtl/rca4_sum_accumulator.sv
// Sums BLOCK_LEN adder results {cout,sum} into an ACC_WIDTH register and hands the
// block total, with a sticky wrap flag, to the sink over a valid/ready handshake.
module rca4_sum_accumulator #(
  parameter int unsigned ACC_WIDTH = 8,
  parameter int unsigned BLOCK_LEN = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  rca4_sum_accumulator_if.slave        bus
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

  localparam logic [7:0] LAST_CNT = 8'(BLOCK_LEN - 1);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q,   acc_d;
  logic                 ovf_q,   ovf_d;
  logic [7:0]           cnt_q,   cnt_d;

  logic                 xfer;
  logic [ACC_WIDTH:0]   operand;
  logic [ACC_WIDTH:0]   sum_next;

  // in_ready depends on state alone so the producer never sees a combinational loop.
  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_acc   = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_cnt   = cnt_q;

  assign xfer     = bus.in_valid && (state_q == ST_ACCUM);
  assign operand  = (ACC_WIDTH + 1)'({bus.in_cout, bus.in_sum});
  assign sum_next = {1'b0, acc_q} + operand;

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through this block can infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_ACCUM: begin
        if (xfer) begin
          acc_d = sum_next[ACC_WIDTH-1:0];
          ovf_d = ovf_q | sum_next[ACC_WIDTH];
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // The drain edge clears the block; no input is taken in this cycle.
        if (bus.out_ready) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rca4_sum_accumulator.sv
// Self-checking bench: three accumulator configurations driven by directed and random
// stimulus, compared against a running-total model of each block.
module tb_rca4_sum_accumulator;

  logic clk;
  logic rst;

  rca4_sum_accumulator_if #(.ACC_WIDTH(8)) if0 ();
  rca4_sum_accumulator_if #(.ACC_WIDTH(6)) if1 ();
  rca4_sum_accumulator_if #(.ACC_WIDTH(8)) if2 ();

  rca4_sum_accumulator #(.ACC_WIDTH(8), .BLOCK_LEN(4)) u_def (.clk(clk), .rst(rst), .bus(if0));
  rca4_sum_accumulator #(.ACC_WIDTH(6), .BLOCK_LEN(4)) u_w6  (.clk(clk), .rst(rst), .bus(if1));
  rca4_sum_accumulator #(.ACC_WIDTH(8), .BLOCK_LEN(1)) u_b1  (.clk(clk), .rst(rst), .bus(if2));

  typedef struct {
    logic        in_ready;
    logic        out_valid;
    logic        out_ovf;
    logic [15:0] out_acc;
    logic [7:0]  out_cnt;
  } obs_t;

  int unsigned w_cfg [3] = '{8, 6, 8};
  int unsigned l_cfg [3] = '{4, 4, 1};

  // Model: arithmetic total of results accepted in the open block.
  int unsigned m_total [3];
  int unsigned m_cnt   [3];
  bit          m_done  [3];

  int n_checks = 0;
  int n_fail   = 0;
  obs_t o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic obs_t sample(int d);
    obs_t s;
    s.in_ready = 1'b0; s.out_valid = 1'b0; s.out_ovf = 1'b0; s.out_acc = '0; s.out_cnt = '0;
    case (d)
      0: begin
        s.in_ready = if0.in_ready; s.out_valid = if0.out_valid; s.out_ovf = if0.out_ovf;
        s.out_acc = 16'(if0.out_acc); s.out_cnt = if0.out_cnt;
      end
      1: begin
        s.in_ready = if1.in_ready; s.out_valid = if1.out_valid; s.out_ovf = if1.out_ovf;
        s.out_acc = 16'(if1.out_acc); s.out_cnt = if1.out_cnt;
      end
      default: begin
        s.in_ready = if2.in_ready; s.out_valid = if2.out_valid; s.out_ovf = if2.out_ovf;
        s.out_acc = 16'(if2.out_acc); s.out_cnt = if2.out_cnt;
      end
    endcase
    return s;
  endfunction

  task automatic set_in(int d, logic v, logic [3:0] s, logic c, logic r);
    if0.in_valid = 1'b0; if0.in_sum = 4'h0; if0.in_cout = 1'b0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_sum = 4'h0; if1.in_cout = 1'b0; if1.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.in_sum = 4'h0; if2.in_cout = 1'b0; if2.out_ready = 1'b0;
    case (d)
      0:       begin if0.in_valid = v; if0.in_sum = s; if0.in_cout = c; if0.out_ready = r; end
      1:       begin if1.in_valid = v; if1.in_sum = s; if1.in_cout = c; if1.out_ready = r; end
      default: begin if2.in_valid = v; if2.in_sum = s; if2.in_cout = c; if2.out_ready = r; end
    endcase
  endtask

  task automatic check_model(int d, string tag);
    obs_t s;
    int unsigned modv;
    s = sample(d);
    modv = 32'd1 << w_cfg[d];
    check({tag, "/acc"},   32'(s.out_acc),   m_total[d] % modv);
    check({tag, "/ovf"},   32'(s.out_ovf),   32'(m_total[d] >= modv));
    check({tag, "/cnt"},   32'(s.out_cnt),   m_cnt[d]);
    check({tag, "/valid"}, 32'(s.out_valid), 32'(m_done[d]));
    check({tag, "/ready"}, 32'(s.in_ready),  32'(!m_done[d]));
  endtask

  // One clock of stimulus on configuration d, then model update and comparison.
  task automatic step(int d, logic v, logic [3:0] s, logic c, logic r, string tag);
    if (v) set_in(d, v, s, c, r);
    else   set_in(d, v, 4'($urandom), 1'($urandom), r);
    @(posedge clk);
    #1;
    if (!m_done[d]) begin
      if (v) begin
        m_total[d] += 32'({c, s});
        m_cnt[d]++;
        if (m_cnt[d] == l_cfg[d]) m_done[d] = 1'b1;
      end
    end else if (r) begin
      m_total[d] = 0;
      m_cnt[d]   = 0;
      m_done[d]  = 1'b0;
    end
    check_model(d, tag);
  endtask

  task automatic do_reset(logic v0, logic r0);
    rst = 1'b1;
    set_in(0, v0, 4'hF, 1'b1, r0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      m_total[d] = 0;
      m_cnt[d]   = 0;
      m_done[d]  = 1'b0;
    end
    check_model(0, "rst0");
    check_model(1, "rst1");
    check_model(2, "rst2");
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 1'b0, 4'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0);

    // Basic block: 3 + 16 + 16 + 16 = 51.
    step(0, 1, 4'd3, 0, 0, "basic1");
    check("basic1/cnt_step", 32'(if0.out_cnt), 32'd1);
    step(0, 1, 4'd0, 1, 0, "basic2");
    check("basic2/cnt_step", 32'(if0.out_cnt), 32'd2);
    step(0, 1, 4'd0, 1, 0, "basic3");
    check("basic3/cnt_step", 32'(if0.out_cnt), 32'd3);
    step(0, 1, 4'd0, 1, 0, "basic4");
    o = sample(0);
    check("basic/acc",   32'(o.out_acc),   32'h33);
    check("basic/valid", 32'(o.out_valid), 32'd1);
    check("basic/ovf",   32'(o.out_ovf),   32'd0);
    check("basic/cnt",   32'(o.out_cnt),   32'd4);
    check("basic/ready", 32'(o.in_ready),  32'd0);
    step(0, 0, 4'd0, 0, 1, "basic_drain");
    check("basic_drain/acc", 32'(if0.out_acc), 32'd0);

    // Overflow at 6 bits: 31 x 4 = 124, wraps on the third result.
    step(1, 1, 4'hF, 1, 0, "ovf1");
    step(1, 1, 4'hF, 1, 0, "ovf2");
    check("ovf2/ovf_clear", 32'(if1.out_ovf), 32'd0);
    step(1, 1, 4'hF, 1, 0, "ovf3");
    check("ovf3/ovf_set", 32'(if1.out_ovf), 32'd1);
    step(1, 1, 4'hF, 1, 0, "ovf4");
    o = sample(1);
    check("ovf/acc",   32'(o.out_acc),   32'd60);
    check("ovf/ovf",   32'(o.out_ovf),   32'd1);
    check("ovf/valid", 32'(o.out_valid), 32'd1);
    step(1, 0, 4'd0, 0, 1, "ovf_drain");
    check("ovf_drain/ovf", 32'(if1.out_ovf), 32'd0);

    // Backpressure: 4 x 23 = 92 held while in_valid keeps offering 5.
    for (int i = 0; i < 4; i++) step(0, 1, 4'd7, 1, 0, "bp_fill");
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 4'd5, 0, 0, "bp_hold");
      o = sample(0);
      check("bp_hold/acc",   32'(o.out_acc),   32'd92);
      check("bp_hold/cnt",   32'(o.out_cnt),   32'd4);
      check("bp_hold/valid", 32'(o.out_valid), 32'd1);
      check("bp_hold/ready", 32'(o.in_ready),  32'd0);
    end
    step(0, 1, 4'd5, 0, 1, "bp_drain");
    check("bp_drain/ready", 32'(if0.in_ready), 32'd1);
    check("bp_drain/cnt",   32'(if0.out_cnt),  32'd0);

    // Gapped input: valid pattern 1,0,0,1,0,1,1 carrying 1,2,3,4.
    step(0, 1, 4'd1, 0, 0, "gap");
    step(0, 0, 4'd0, 0, 0, "gap");
    step(0, 0, 4'd0, 0, 0, "gap");
    step(0, 1, 4'd2, 0, 0, "gap");
    step(0, 0, 4'd0, 0, 0, "gap");
    step(0, 1, 4'd3, 0, 0, "gap");
    step(0, 1, 4'd4, 0, 0, "gap");
    check("gap/acc", 32'(if0.out_acc), 32'd10);
    check("gap/cnt", 32'(if0.out_cnt), 32'd4);
    step(0, 0, 4'd0, 0, 1, "gap_drain");

    // Reset mid-block with in_valid still asserted, then reset in DONE.
    step(0, 1, 4'd9, 1, 0, "rst_mid");
    step(0, 1, 4'd9, 1, 0, "rst_mid");
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 1, 4'd2, 0, 0, "rst_fill");
    step(0, 0, 4'd0, 0, 0, "rst_wait");
    check("rst_wait/valid", 32'(if0.out_valid), 32'd1);
    do_reset(1'b0, 1'b0);
    check("rst_done/valid", 32'(if0.out_valid), 32'd0);

    // BLOCK_LEN=1: every accepted result completes a block.
    step(2, 1, 4'hF, 1, 0, "b1");
    check("b1/acc",   32'(if2.out_acc),   32'd31);
    check("b1/valid", 32'(if2.out_valid), 32'd1);
    step(2, 1, 4'h3, 0, 0, "b1_hold");
    step(2, 0, 4'h0, 0, 1, "b1_drain");

    // Random traffic on all three configurations.
    for (int i = 0; i < 200; i++)
      step(0, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom),
           ($urandom_range(0, 2) == 0), "rnd0");
    for (int i = 0; i < 120; i++)
      step(1, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom),
           ($urandom_range(0, 2) == 0), "rnd1");
    for (int i = 0; i < 120; i++)
      step(2, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom),
           ($urandom_range(0, 2) == 0), "rnd2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rca4_sum_accumulator.md
Name: rca4_sum_accumulator

Overview:
Downstream consumer of the 4-bit ripple-carry adder. It captures each adder result {Cout, Sum} (a 5-bit value, 0..31) through a valid/ready handshake and accumulates BLOCK_LEN results into a wider register. When the block is complete, it presents the total with a sticky overflow flag through a valid/ready output handshake. It sits between the adder datapath and any result sink or checker.

Parameters:
- ACC_WIDTH, 8, accumulator width in bits; legal range 5..16.
- BLOCK_LEN, 4, adder results summed per output block; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_sum/in_cout hold a valid adder result.
- in_ready  output  1  block can accept a result this cycle.
- in_sum  input  4  adder Sum.
- in_cout  input  1  adder Cout.
- out_valid  output  1  out_acc/out_ovf hold a completed block total.
- out_ready  input  1  sink accepts the block total.
- out_acc  output  ACC_WIDTH  accumulator value.
- out_ovf  output  1  sticky flag: accumulator wrapped during the current block.
- out_cnt  output  8  number of results accepted in the current block.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=ACCUM; out_acc=0, out_ovf=0, out_cnt=0, out_valid=0.
  - Reset overrides every other input in any state, including mid-block and in DONE with out_valid=1.
- State ACCUM:
  - in_ready=1 (combinational from state only; no dependence on in_valid or out_ready).
  - Transfer occurs when in_valid && in_ready.
  - On transfer:
    - operand = zero-extend {in_cout, in_sum} to ACC_WIDTH+1 bits.
    - sum_next = out_acc + operand.
    - out_acc <= sum_next[ACC_WIDTH-1:0] (modulo wrap).
    - If sum_next[ACC_WIDTH]=1, out_ovf <= 1. out_ovf is sticky until the block is drained.
    - out_cnt <= out_cnt + 1.
  - If a transfer occurs with out_cnt == BLOCK_LEN-1: next state=DONE, out_valid <= 1 on the same edge. Latency from the last accepted input to out_valid is 1 cycle.
  - No transfer: all registers hold.
- State DONE:
  - in_ready=0; in_valid and in_sum/in_cout are ignored.
  - out_acc, out_ovf and out_cnt (=BLOCK_LEN) are stable while out_valid=1 && out_ready=0.
  - On out_valid && out_ready:
    - Next edge: state=ACCUM, out_valid=0, out_acc=0, out_ovf=0, out_cnt=0.
    - No input is accepted in the drain cycle, so there is at least one cycle between blocks where in_ready=0.
- out_ready asserted while in ACCUM has no effect.
- BLOCK_LEN=1: every accepted result goes straight to DONE.
- Maximum operand 31 (in_cout=1, in_sum=4'hF) must be handled. Any input with in_cout=1 adds at least 16.
- in_sum/in_cout are sampled only on a transfer edge; X on these inputs when in_valid=0 must not corrupt state.

Test Plan:
- Basic block (defaults): feed (in_sum,in_cout) = (3,0), (0,1), (0,1), (0,1), one per cycle.
  - out_cnt must step 1,2,3.
  - One cycle after the 4th transfer: out_valid=1, out_acc=8'h33 (51), out_ovf=0, out_cnt=4, in_ready=0.
  - One out_ready pulse returns the block to ACCUM with out_acc=0.
- Overflow (ACC_WIDTH=6): feed four results of (15,1) = 31 each.
  - out_ovf must go to 1 on the 3rd transfer (93 > 63) and stay 1.
  - Final out_acc=60 (124 mod 64), out_valid=1, out_ovf=1.
  - After drain, out_ovf=0.
- Output backpressure: complete a block, hold out_ready=0 for 3 cycles while driving in_valid=1 with (5,0).
  - out_valid, out_acc and out_cnt must stay constant; in_ready=0; no input is consumed.
  - With out_ready=1, exactly one cycle passes before in_ready=1.
- Gapped input: in_valid pattern 1,0,0,1,0,1,1 with operands 1,2,3,4.
  - Only the valid cycles count; final out_acc=10, out_cnt=4.
- Reset mid-operation:
  - Assert rst after 2 transfers: next edge gives out_acc=0, out_cnt=0, out_ovf=0, in_ready=1.
  - Assert rst again in DONE with out_valid=1 and out_ready=0: out_valid must be 0 after that edge.
